axi_lite_uart_responder: RTL

- AXI4-Lite slave that models a UART-Lite register file: RX FIFO, TX FIFO, STAT and CTRL registers.
- Responds to the core-side io_controller initiator, which drives axi_aw*/w*/b*/ar*/r*.
- Drains the TX FIFO to a byte stream toward the serializer, and fills the RX FIFO from a byte stream from the deserializer.
- Used as a simulation responder and as the on-chip target when no vendor UART IP is present.

---
 rtl/uart_lite_pkg.sv | 18 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/axi_lite_uart_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_lite_pkg.sv
// Shared register offsets, STAT bit positions and response code for the
// AXI4-Lite UART-Lite responder.
package uart_lite_pkg;

  localparam logic [3:0] RX_OFS   = 4'h0;
  localparam logic [3:0] TX_OFS   = 4'h4;
  localparam logic [3:0] STAT_OFS = 4'h8;
  localparam logic [3:0] CTRL_OFS = 4'hC;

  localparam int STAT_RX_NE    = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_OVR      = 5;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head, same-cycle push/pop and a
// flush that overrides any concurrent push or pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign dout  = mem_q[rd_q];

  // A push into a full FIFO is still taken when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_lite_uart_responder.sv
// AXI4-Lite slave modelling a UART-Lite register file: RX/TX byte FIFOs,
// STAT and CTRL, with byte streams toward the serializer/deserializer.
module axi_lite_uart_responder
  import uart_lite_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_DEC_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [2:0]  axi_arprot,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data
);

  localparam logic [ADDR_DEC_W-1:0] A_RX   = ADDR_DEC_W'(RX_OFS);
  localparam logic [ADDR_DEC_W-1:0] A_TX   = ADDR_DEC_W'(TX_OFS);
  localparam logic [ADDR_DEC_W-1:0] A_STAT = ADDR_DEC_W'(STAT_OFS);
  localparam logic [ADDR_DEC_W-1:0] A_CTRL = ADDR_DEC_W'(CTRL_OFS);

  logic                  aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d, ovr_q, ovr_d;
  logic [ADDR_DEC_W-1:0] waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  wstrb0_q, wstrb0_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           stat;
  logic                  aw_hs, w_hs, ar_hs, fire;
  logic                  tx_push, tx_flush, tx_empty, tx_full;
  logic                  rx_pop, rx_flush, rx_empty, rx_full, stat_rd;
  logic [7:0]            rx_dout;
  logic                  unused_inputs;

  assign unused_inputs = ^{axi_awprot, axi_arprot, axi_awaddr[31:ADDR_DEC_W],
                           axi_araddr[31:ADDR_DEC_W], axi_wdata[31:8], axi_wstrb[3:1]};

  // Readies are forced low while reset is held so the bus sees an idle slave.
  assign axi_awready = ~rst & ~aw_lat_q & ~bvalid_q;
  assign axi_wready  = ~rst & ~w_lat_q & ~bvalid_q;
  assign axi_arready = ~rst & ~rvalid_q;
  assign rx_ready    = ~rst;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = RESP_OKAY;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = RESP_OKAY;
  assign tx_valid    = ~tx_empty;

  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid & axi_wready;
  assign ar_hs = axi_arvalid & axi_arready;
  assign fire  = aw_lat_q & w_lat_q;

  always_comb begin
    stat                = '0;
    stat[STAT_RX_NE]    = ~rx_empty;
    stat[STAT_RX_FULL]  = rx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_TX_FULL]  = tx_full;
    stat[STAT_OVR]      = ovr_q;
  end

  always_comb begin
    aw_lat_d = aw_lat_q;
    w_lat_d  = w_lat_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wstrb0_d = wstrb0_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    ovr_d    = ovr_q;
    tx_push  = 1'b0;
    tx_flush = 1'b0;
    rx_flush = 1'b0;
    rx_pop   = 1'b0;
    stat_rd  = 1'b0;

    if (aw_hs) begin
      aw_lat_d = 1'b1;
      waddr_d  = axi_awaddr[ADDR_DEC_W-1:0];
    end
    if (w_hs) begin
      w_lat_d  = 1'b1;
      wdata_d  = axi_wdata[7:0];
      wstrb0_d = axi_wstrb[0];
    end
    if (bvalid_q && axi_bready) bvalid_d = 1'b0;
    if (fire) begin
      aw_lat_d = 1'b0;
      w_lat_d  = 1'b0;
      bvalid_d = 1'b1;
      case (waddr_q)
        A_TX:   tx_push = wstrb0_q;
        A_CTRL: begin
          tx_flush = wdata_q[0];
          rx_flush = wdata_q[1];
        end
        default: ;
      endcase
    end

    // Side effects happen at the AR handshake so each read acts exactly once.
    if (rvalid_q && axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (axi_araddr[ADDR_DEC_W-1:0])
        A_RX: begin
          rdata_d = rx_empty ? 32'h0 : {24'h0, rx_dout};
          rx_pop  = ~rx_empty;
        end
        A_STAT: begin
          rdata_d = stat;
          stat_rd = 1'b1;
        end
        default: rdata_d = 32'h0;
      endcase
    end

    if (stat_rd) ovr_d = 1'b0;
    if (rx_valid && rx_full && !rx_pop) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_lat_q <= 1'b0;
      w_lat_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb0_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      aw_lat_q <= aw_lat_d;
      w_lat_q  <= w_lat_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb0_q <= wstrb0_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ovr_q    <= ovr_d;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_valid & tx_ready),
    .flush (tx_flush),
    .din   (wdata_q),
    .dout  (tx_data),
    .empty (tx_empty),
    .full  (tx_full)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_data),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

endmodule
